ifu_fetch_redirect: RTL and testbench

- Instruction-fetch front end. Owns the architectural PC and issues in-order word fetches to the instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Consumes the taken-branch/jump redirect (jump enable + target address) produced by the execute-stage branch/jump unit.
- On a redirect it flushes buffered instructions, discards in-flight responses and restarts fetch at the target.

---
 rtl/ifu_fetch_redirect_pkg.sv | 18 +
 rtl/ifu_fetch_redirect_if.sv | 35 +++
 rtl/ifu_fetch_redirect_ibuf_fifo.sv | 70 +++++++
 rtl/ifu_fetch_redirect.sv | 123 ++++++++++++
 tb/tb_ifu_fetch_redirect.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_redirect_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the fetch FSM state encoding, the default reset PC, the instruction
// size in bytes, and a helper that word-aligns a redirect target.
package ifu_fetch_redirect_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/ifu_fetch_redirect_if.sv
// Bundle of the fetch unit's handshake buses.
//   redirect : i_jump_en, i_jump_addr          (execute -> fetch)
//   imem req : o_imem_req_valid, i_imem_req_ready, o_imem_addr
//   imem rsp : i_imem_rsp_valid, i_imem_rsp_data
//   decode   : o_ifu_valid, i_ifu_ready, o_ifu_instr, o_ifu_pc
// slave  : the fetch unit itself.
// master : everything around it (execute, memory, decode).
interface ifu_fetch_redirect_if;
    import ifu_fetch_redirect_pkg::*;

    logic        i_jump_en;
    logic [31:0] i_jump_addr;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_ifu_valid;
    logic        i_ifu_ready;
    logic [31:0] o_ifu_instr;
    logic [31:0] o_ifu_pc;

    modport slave (
        input  i_jump_en, i_jump_addr, i_imem_req_ready, i_imem_rsp_valid,
               i_imem_rsp_data, i_ifu_ready,
        output o_imem_req_valid, o_imem_addr, o_ifu_valid, o_ifu_instr, o_ifu_pc
    );

    modport master (
        output i_jump_en, i_jump_addr, i_imem_req_ready, i_imem_rsp_valid,
               i_imem_rsp_data, i_ifu_ready,
        input  o_imem_req_valid, o_imem_addr, o_ifu_valid, o_ifu_instr, o_ifu_pc
    );

endinterface

// File: rtl/ifu_fetch_redirect_ibuf_fifo.sv
// Instruction buffer: FIFO_DEPTH entries of {pc, instr}.
// Ports: i_clk, i_rst (async, active-high), i_push/i_push_data,
//        i_pop, i_flush, o_head_data (entry at the head), o_count.
// Flush empties the buffer and wins over a same-cycle push or pop.
// No bypass: a pushed entry is visible the cycle after the push.
module ifu_ibuf_fifo
    import ifu_fetch_redirect_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [63:0]   i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [63:0]   o_head_data,
    output logic [CW-1:0] o_count
);

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_push     = i_push & ~i_flush;
    assign do_pop      = i_pop & ~i_flush & (count_q != '0);
    assign o_head_data = mem_q[rd_ptr_q];
    assign o_count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the top masks the head while the buffer is empty.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/ifu_fetch_redirect.sv
// Instruction-fetch front end with branch/jump redirect.
// Owns the architectural PC, issues in-order word fetches, buffers the
// returned words with their PCs and hands them to decode (valid/ready).
// A redirect flushes the buffer, restarts fetch at the target and drops
// the responses of fetches that were still in flight.
// Ports: i_clk, i_rst (async, active-high), bus (ifu_fetch_redirect_if.slave).
module ifu_fetch_redirect
    import ifu_fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ifu_fetch_redirect_if.slave  bus
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] squash_q, squash_d;

    logic [CW-1:0] fifo_count;
    logic [63:0]   fifo_head;
    logic [CW:0]   inflight;
    logic [31:0]   jump_tgt;
    logic          req_valid, req_fire, rsp_live;
    logic          push, pop, flush, ifu_valid;

    assign jump_tgt  = word_align(bus.i_jump_addr);
    assign inflight  = {1'b0, outst_q} + {1'b0, fifo_count};
    // Credit rule: never have more words requested or buffered than slots.
    assign req_valid = (state_q == ST_FETCH) && (inflight < DEPTH_C) && !bus.i_jump_en;
    assign req_fire  = req_valid & bus.i_imem_req_ready;
    // Responses with nothing outstanding belong to fetches issued before a reset.
    assign rsp_live  = bus.i_imem_rsp_valid && (outst_q != '0);
    assign ifu_valid = (state_q != ST_DRAIN) && (fifo_count != '0);
    assign pop       = ifu_valid & bus.i_ifu_ready;

    assign bus.o_imem_req_valid = req_valid;
    assign bus.o_imem_addr      = pc_q;
    assign bus.o_ifu_valid      = ifu_valid;
    assign bus.o_ifu_instr      = ifu_valid ? fifo_head[31:0]  : '0;
    assign bus.o_ifu_pc         = ifu_valid ? fifo_head[63:32] : '0;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q;
        squash_d  = squash_q;
        push      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.i_jump_en) begin
                    // In-flight words become squash credits; a response landing
                    // this very cycle is already stale and is simply not pushed.
                    pc_d      = jump_tgt;
                    resp_pc_d = jump_tgt;
                    flush     = 1'b1;
                    outst_d   = '0;
                    squash_d  = outst_q - CW'(rsp_live);
                    state_d   = (squash_d != '0) ? ST_DRAIN : ST_FETCH;
                end else begin
                    if (req_fire) pc_d = pc_q + INSTR_BYTES;
                    if (rsp_live) begin
                        push      = 1'b1;
                        resp_pc_d = resp_pc_q + INSTR_BYTES;
                    end
                    outst_d = outst_q + CW'(req_fire) - CW'(rsp_live);
                end
            end
            ST_DRAIN: begin
                // A further redirect only moves the restart point; the stale
                // responses still pending are counted by squash as before.
                if (bus.i_jump_en) begin
                    pc_d      = jump_tgt;
                    resp_pc_d = jump_tgt;
                end
                if (squash_q == '0) begin
                    state_d = ST_FETCH;
                end else if (bus.i_imem_rsp_valid) begin
                    squash_d = squash_q - CW'(1);
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            squash_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            squash_q  <= squash_d;
        end
    end

    ifu_ibuf_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_ibuf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data ({resp_pc_q, bus.i_imem_rsp_data}),
        .i_pop       (pop),
        .i_flush     (flush),
        .o_head_data (fifo_head),
        .o_count     (fifo_count)
    );

endmodule

// File: tb/tb_ifu_fetch_redirect.sv
module tb_ifu_fetch_redirect;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_redirect_if bus();

  ifu_fetch_redirect #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Memory model: in-order responses, each due a chosen number of cycles after acceptance.
  typedef struct {
    logic [31:0] data;
    int          due;
    int          epoch;
  } mreq_t;
  mreq_t mq[$];

  int n_chk = 0, n_err = 0, n_pop = 0, cyc = 0, epoch = 0;
  logic [31:0] exp_fetch, exp_dec;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC001_D00D;
  endfunction

  // One clock: drive inputs, sample outputs, check against the stream model, commit.
  task automatic tick(input logic jmp, input logic [31:0] jaddr, input logic mrdy,
                      input logic drdy, input int lat);
    int   stale;
    logic rsp;
    @(negedge clk);
    bus.i_jump_en = jmp; bus.i_jump_addr = jaddr;
    bus.i_imem_req_ready = mrdy; bus.i_ifu_ready = drdy;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.i_imem_rsp_valid = rsp;
    bus.i_imem_rsp_data  = rsp ? mq[0].data : $urandom;
    #1;
    s_rv = bus.o_imem_req_valid; s_addr = bus.o_imem_addr;
    s_iv = bus.o_ifu_valid; s_pc = bus.o_ifu_pc; s_instr = bus.o_ifu_instr;
    stale = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
    n_chk++;
    if (mq.size() > DEPTH) begin
      n_err++; $display("FAIL inflight_bound: %0d in flight, limit %0d", mq.size(), DEPTH);
    end
    if (stale > 0) begin
      n_chk++;
      if (s_rv !== 1'b0 || s_iv !== 1'b0) begin
        n_err++; $display("FAIL drain_quiet: req_valid=%b ifu_valid=%b, both required 0", s_rv, s_iv);
      end
    end
    if (jmp) begin
      n_chk++;
      if (s_rv !== 1'b0) begin
        n_err++; $display("FAIL req_on_jump: req_valid=%b required 0", s_rv);
      end
    end
    if (s_rv === 1'b1) begin
      n_chk++;
      if (s_addr !== exp_fetch) begin
        n_err++; $display("FAIL fetch_addr: got %h required %h", s_addr, exp_fetch);
      end
    end
    if (s_iv === 1'b1 && drdy) begin
      n_chk++;
      if (s_pc !== exp_dec || s_instr !== mem_word(exp_dec)) begin
        n_err++; $display("FAIL decode: pc %h instr %h, required pc %h instr %h",
                          s_pc, s_instr, exp_dec, mem_word(exp_dec));
      end
      exp_dec = exp_dec + 32'd4;
      n_pop++;
    end
    @(posedge clk);
    if (rsp) void'(mq.pop_front());
    if (s_rv === 1'b1 && mrdy) begin
      mq.push_back('{data: mem_word(s_addr), due: cyc + lat, epoch: epoch});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (jmp) begin
      epoch++;
      exp_fetch = {jaddr[31:2], 2'b00};
      exp_dec   = {jaddr[31:2], 2'b00};
    end
    cyc++;
  endtask

  // Asserts reset away from any clock edge, checks reset outputs, releases into BOOT.
  task automatic test_reset();
    #2;
    rst = 1'b1;
    bus.i_jump_en = 1'b0; bus.i_jump_addr = '0; bus.i_imem_req_ready = 1'b0;
    bus.i_imem_rsp_valid = 1'b0; bus.i_imem_rsp_data = '0; bus.i_ifu_ready = 1'b0;
    #1;
    n_chk++;
    if (bus.o_imem_req_valid !== 1'b0 || bus.o_ifu_valid !== 1'b0 || bus.o_imem_addr !== RPC ||
        bus.o_ifu_instr !== 32'h0 || bus.o_ifu_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: rv=%b iv=%b addr=%h instr=%h pc=%h, required 0 0 %h 0 0",
                        bus.o_imem_req_valid, bus.o_ifu_valid, bus.o_imem_addr,
                        bus.o_ifu_instr, bus.o_ifu_pc, RPC);
    end
    mq.delete();
    epoch++;
    exp_fetch = RPC; exp_dec = RPC;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (bus.o_imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL boot_idle: req_valid=%b required 0", bus.o_imem_req_valid);
    end
  endtask

  task automatic test_basic();
    int first_req = -1, first_vld = -1;
    logic [31:0] first_addr = 32'hx;
    logic [31:0] pops[$];
    test_reset();
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, '0, 1'b1, 1'b1, 1);
      if (s_rv === 1'b1 && first_req < 0) begin first_req = k; first_addr = s_addr; end
      if (s_iv === 1'b1 && first_vld < 0) first_vld = k;
      if (s_iv === 1'b1) pops.push_back(s_pc);
    end
    n_chk++;
    if (first_req != 1 || first_addr !== 32'h0) begin
      n_err++; $display("FAIL basic_first_req: cycle %0d addr %h, required cycle 1 addr 0", first_req, first_addr);
    end
    n_chk++;
    if (first_vld != 3) begin
      n_err++; $display("FAIL basic_latency: first valid cycle %0d, required 3", first_vld);
    end
    n_chk++;
    if (pops.size() < 3 || pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8) begin
      n_err++; $display("FAIL basic_pc_seq: %0d pops, first %h, required 0,4,8", pops.size(),
                        (pops.size() > 0) ? pops[0] : 32'hx);
    end
  endtask

  task automatic test_stall();
    test_reset();
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0, '0, 1'b1, 1'b0, 1);
      if (k >= 4) begin
        n_chk++;
        if (s_rv !== 1'b0 || s_iv !== 1'b1 || s_pc !== 32'h0) begin
          n_err++; $display("FAIL stall_full: rv=%b iv=%b pc=%h, required 0 1 0", s_rv, s_iv, s_pc);
        end
      end
    end
    tick(1'b0, '0, 1'b1, 1'b1, 1);
    n_chk++;
    if (s_rv !== 1'b0 || s_pc !== 32'h0) begin
      n_err++; $display("FAIL stall_release0: rv=%b pc=%h, required 0 0", s_rv, s_pc);
    end
    tick(1'b0, '0, 1'b1, 1'b1, 1);
    n_chk++;
    if (s_pc !== 32'h4 || s_rv !== 1'b1 || s_addr !== 32'h8) begin
      n_err++; $display("FAIL stall_resume: pc=%h rv=%b addr=%h, required 4 1 8", s_pc, s_rv, s_addr);
    end
    // Leave a full buffer so the following reset has non-zero outputs to clear.
    repeat (5) tick(1'b0, '0, 1'b1, 1'b0, 1);
  endtask

  task automatic test_boot_jump();
    test_reset();
    bus.i_jump_en = 1'b1; bus.i_jump_addr = 32'h0000_0400;
    tick(1'b0, '0, 1'b1, 1'b1, 1);
    n_chk++;
    if (s_rv !== 1'b1 || s_addr !== RPC) begin
      n_err++; $display("FAIL boot_jump: rv=%b addr=%h, required 1 %h", s_rv, s_addr, RPC);
    end
  endtask

  task automatic test_redirect_drain();
    bit seen = 0;
    test_reset();
    tick(1'b0, '0, 1'b1, 1'b1, 3);
    tick(1'b0, '0, 1'b1, 1'b1, 3);
    tick(1'b1, 32'h0000_0103, 1'b1, 1'b1, 3);
    for (int k = 4; k <= 6; k++) begin
      tick(1'b0, '0, 1'b1, 1'b1, 3);
      n_chk++;
      if (s_rv !== 1'b0 || s_iv !== 1'b0) begin
        n_err++; $display("FAIL drain_cycle%0d: rv=%b iv=%b, required 0 0", k, s_rv, s_iv);
      end
    end
    tick(1'b0, '0, 1'b1, 1'b1, 3);
    n_chk++;
    if (s_rv !== 1'b1 || s_addr !== 32'h100) begin
      n_err++; $display("FAIL drain_restart: rv=%b addr=%h, required 1 00000100", s_rv, s_addr);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1'b0, '0, 1'b1, 1'b1, 3);
      if (s_iv === 1'b1) begin
        seen = 1;
        n_chk++;
        if (s_pc !== 32'h100) begin
          n_err++; $display("FAIL drain_first_pc: got %h required 00000100", s_pc);
        end
      end
    end
    if (!seen) begin
      n_chk++; n_err++; $display("FAIL drain_first_pc: no instruction within 10 cycles");
    end
  endtask

  task automatic test_jump_with_rsp();
    bit seen = 0;
    test_reset();
    tick(1'b0, '0, 1'b1, 1'b1, 3);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, '0, 1'b0, 1'b1, 3);
      n_chk++;
      if (s_rv !== 1'b1 || s_addr !== 32'h4) begin
        n_err++; $display("FAIL held_req: rv=%b addr=%h, required 1 00000004", s_rv, s_addr);
      end
    end
    tick(1'b1, 32'h0000_0200, 1'b1, 1'b1, 3);
    tick(1'b0, '0, 1'b1, 1'b1, 3);
    n_chk++;
    if (s_rv !== 1'b1 || s_addr !== 32'h200 || s_iv !== 1'b0) begin
      n_err++; $display("FAIL jump_rsp_restart: rv=%b addr=%h iv=%b, required 1 00000200 0", s_rv, s_addr, s_iv);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1'b0, '0, 1'b1, 1'b1, 3);
      if (s_iv === 1'b1) begin
        seen = 1;
        n_chk++;
        if (s_pc !== 32'h200) begin
          n_err++; $display("FAIL jump_rsp_first_pc: got %h required 00000200", s_pc);
        end
      end
    end
    if (!seen) begin
      n_chk++; n_err++; $display("FAIL jump_rsp_first_pc: no instruction within 10 cycles");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pops[$];
    test_reset();
    tick(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1);
    tick(1'b0, '0, 1'b1, 1'b1, 1);
    n_chk++;
    if (s_rv !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_first: rv=%b addr=%h, required 1 fffffffc", s_rv, s_addr);
    end
    tick(1'b0, '0, 1'b1, 1'b1, 1);
    n_chk++;
    if (s_rv !== 1'b1 || s_addr !== 32'h0) begin
      n_err++; $display("FAIL wrap_next: rv=%b addr=%h, required 1 00000000", s_rv, s_addr);
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, '0, 1'b1, 1'b1, 1);
      if (s_iv === 1'b1) pops.push_back(s_pc);
    end
    n_chk++;
    if (pops.size() < 2 || pops[0] !== 32'hFFFF_FFFC || pops[1] !== 32'h0) begin
      n_err++; $display("FAIL wrap_pcs: %0d pops, first %h, required fffffffc then 0",
                        pops.size(), (pops.size() > 0) ? pops[0] : 32'hx);
    end
  endtask

  task automatic test_reset_mid_drain();
    test_reset();
    tick(1'b0, '0, 1'b1, 1'b1, 6);
    tick(1'b0, '0, 1'b1, 1'b1, 6);
    tick(1'b1, 32'h0000_0100, 1'b1, 1'b1, 6);
    @(negedge clk);
    bus.i_jump_en = 1'b0;
    #1;
    n_chk++;
    if (bus.o_imem_addr !== 32'h100 || bus.o_imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_drain_state: addr=%h rv=%b, required 00000100 0",
                        bus.o_imem_addr, bus.o_imem_req_valid);
    end
    test_reset();
    tick(1'b0, '0, 1'b1, 1'b1, 1);
    n_chk++;
    if (s_rv !== 1'b1 || s_addr !== RPC) begin
      n_err++; $display("FAIL post_reset_fetch: rv=%b addr=%h, required 1 %h", s_rv, s_addr, RPC);
    end
    repeat (6) tick(1'b0, '0, 1'b1, 1'b1, 1);
  endtask

  task automatic test_random();
    int pops_before;
    test_reset();
    pops_before = n_pop;
    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 39) == 0, $urandom, ($urandom % 4) != 0,
           ($urandom % 10) < 7, $urandom_range(1, 4));
    end
    n_chk++;
    if (n_pop - pops_before < 200) begin
      n_err++; $display("FAIL random_progress: %0d instructions decoded, required at least 200",
                        n_pop - pops_before);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_boot_jump();
    test_redirect_drain();
    test_jump_with_rsp();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
